// File: rtl/aes_round_ctrl_if.sv
// Handshake and control bundle between the AES round controller and its environment.
`timescale 1ns/1ps
interface aes_round_ctrl_if;
  logic       start;
  logic       decrypt;
  logic [1:0] key_size;
  logic       abort;
  logic       key_valid;
  logic       out_ready;
  logic       busy;
  logic       ld_state;
  logic       sub_bytes;
  logic       shift_rows;
  logic       mix_cols;
  logic       add_key;
  logic       inverse;
  logic       key_req;
  logic [3:0] key_idx;
  logic [3:0] round;
  logic       out_valid;
  logic       err;

  modport master (
    output start, decrypt, key_size, abort, key_valid, out_ready,
    input  busy, ld_state, sub_bytes, shift_rows, mix_cols, add_key,
           inverse, key_req, key_idx, round, out_valid, err
  );

  modport slave (
    input  start, decrypt, key_size, abort, key_valid, out_ready,
    output busy, ld_state, sub_bytes, shift_rows, mix_cols, add_key,
           inverse, key_req, key_idx, round, out_valid, err
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: walks encrypt/decrypt round schedules for 128/192/256-bit keys,
// issuing one datapath strobe per op state and fetching round keys from the expander.
`timescale 1ns/1ps
module aes_round_ctrl (
  input  logic             clk,
  input  logic             reset,
  aes_round_ctrl_if.slave  bus
);

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    KWAIT = 3'd2,
    ADDK  = 3'd3,
    SUB   = 3'd4,
    SHIFT = 3'd5,
    MIX   = 3'd6,
    OUT   = 3'd7
  } state_e;

  state_e             state, state_next;
  logic               dec_q, dec_next;
  logic [IDX_W-1:0]   nr_q, nr_next;
  logic [IDX_W-1:0]   round_q, round_next;
  logic [IDX_W-1:0]   kidx_q, kidx_next;
  logic [IDX_W-1:0]   nr_sel;
  logic [IDX_W-1:0]   round_inc;
  logic               last_round;
  logic               err_next;

  // Round count selected by the key size presented with start
  always_comb begin
    nr_sel = IDX_W'(10);
    case (bus.key_size)
      2'b01:   nr_sel = IDX_W'(12);
      2'b10:   nr_sel = IDX_W'(14);
      default: nr_sel = IDX_W'(10);
    endcase
  end

  assign round_inc  = round_q + IDX_W'(1);
  assign last_round = (round_q == nr_q);

  // Next-state, round bookkeeping and key index selection
  always_comb begin
    state_next = state;
    dec_next   = dec_q;
    nr_next    = nr_q;
    round_next = round_q;
    kidx_next  = kidx_q;
    err_next   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.key_size == 2'b11) begin
            err_next = 1'b1;
          end else begin
            dec_next   = bus.decrypt;
            nr_next    = nr_sel;
            round_next = '0;
            kidx_next  = bus.decrypt ? nr_sel : '0;
            state_next = LOAD;
          end
        end
      end
      LOAD:  state_next = KWAIT;
      KWAIT: if (bus.key_valid) state_next = ADDK;
      ADDK: begin
        if (last_round) begin
          state_next = OUT;
        end else begin
          round_next = round_inc;
          kidx_next  = dec_q ? IDX_W'(nr_q - round_inc) : round_inc;
          // Decrypt applies InvMixColumns after every AddRoundKey except round 0's
          if (dec_q) state_next = (round_q == '0) ? SHIFT : MIX;
          else       state_next = SUB;
        end
      end
      SUB:   state_next = dec_q ? KWAIT : SHIFT;
      SHIFT: begin
        if (dec_q)           state_next = SUB;
        else if (last_round) state_next = KWAIT;
        else                 state_next = MIX;
      end
      MIX:   state_next = dec_q ? SHIFT : KWAIT;
      OUT:   if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Cancel wins over every other condition once a block is in flight
    if (bus.abort && (state != IDLE)) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      dec_q   <= 1'b0;
      nr_q    <= IDX_W'(10);
      round_q <= '0;
      kidx_q  <= '0;
    end else begin
      state   <= state_next;
      dec_q   <= dec_next;
      nr_q    <= nr_next;
      round_q <= round_next;
      kidx_q  <= kidx_next;
    end
  end

  // Outputs registered from the next-state decode so they align with the state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy       <= 1'b0;
      bus.ld_state   <= 1'b0;
      bus.sub_bytes  <= 1'b0;
      bus.shift_rows <= 1'b0;
      bus.mix_cols   <= 1'b0;
      bus.add_key    <= 1'b0;
      bus.key_req    <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.err        <= 1'b0;
      bus.inverse    <= 1'b0;
      bus.key_idx    <= '0;
      bus.round      <= '0;
    end else begin
      bus.busy       <= (state_next != IDLE);
      bus.ld_state   <= (state_next == LOAD);
      bus.sub_bytes  <= (state_next == SUB);
      bus.shift_rows <= (state_next == SHIFT);
      bus.mix_cols   <= (state_next == MIX);
      bus.add_key    <= (state_next == ADDK);
      bus.key_req    <= (state_next == KWAIT);
      bus.out_valid  <= (state_next == OUT);
      bus.err        <= err_next;
      bus.inverse    <= dec_next;
      bus.key_idx    <= kidx_next;
      bus.round      <= round_next;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: per-cycle strobe traces compared to a schedule model.
`timescale 1ns/1ps
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  // Trace event codes: 1 load, 2 sub, 3 shift, 4 mix, 16+k key wait, 32+k add key, 64 out, 255 illegal
  int   got[$];
  int   exp_q[$];

  aes_round_ctrl_if bus ();

  aes_round_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int nr_of(input logic [1:0] ks);
    return 10 + 2 * int'(ks);
  endfunction

  function automatic int strobes();
    return int'(bus.ld_state) + int'(bus.sub_bytes) + int'(bus.shift_rows) +
           int'(bus.mix_cols) + int'(bus.add_key) + int'(bus.key_req) + int'(bus.out_valid);
  endfunction

  function automatic int cur_event();
    if (strobes() != 1)  return 255;
    if (bus.ld_state)    return 1;
    if (bus.sub_bytes)   return 2;
    if (bus.shift_rows)  return 3;
    if (bus.mix_cols)    return 4;
    if (bus.key_req)     return 16 + int'(bus.key_idx);
    if (bus.add_key)     return 32 + int'(bus.key_idx);
    return 64;
  endfunction

  // Reference schedule built straight from the AES round structure
  function automatic void push_key(input int k, input int stall);
    for (int s = 0; s <= stall; s++) exp_q.push_back(16 + k);
    exp_q.push_back(32 + k);
  endfunction

  function automatic void build_exp(input bit dec, input int nr, input int stall, input int outwait);
    exp_q.delete();
    exp_q.push_back(1);
    if (!dec) begin
      push_key(0, stall);
      for (int r = 1; r <= nr; r++) begin
        exp_q.push_back(2);
        exp_q.push_back(3);
        if (r < nr) exp_q.push_back(4);
        push_key(r, stall);
      end
    end else begin
      push_key(nr, stall);
      for (int r = 1; r <= nr; r++) begin
        exp_q.push_back(3);
        exp_q.push_back(2);
        push_key(nr - r, stall);
        if (r < nr) exp_q.push_back(4);
      end
    end
    for (int i = 0; i <= outwait; i++) exp_q.push_back(64);
  endfunction

  function automatic int exp_latency(input int nr, input int stall);
    return 8 + 5 * (nr - 1) + (nr + 1) * stall;
  endfunction

  function automatic int first_diff();
    if (got.size() != exp_q.size()) return -2;
    for (int i = 0; i < got.size(); i++) if (got[i] != exp_q[i]) return i;
    return -1;
  endfunction

  function automatic int count_ev(input int code);
    int n = 0;
    foreach (got[i]) if (got[i] == code) n++;
    return n;
  endfunction

  function automatic void idle_inputs();
    bus.start     = 1'b0;
    bus.decrypt   = 1'b0;
    bus.key_size  = 2'b00;
    bus.abort     = 1'b0;
    bus.key_valid = 1'b1;
    bus.out_ready = 1'b1;
  endfunction

  // Runs one block with a reactive key expander and consumer; records the strobe trace
  task automatic run_op(input bit dec, input logic [1:0] ks, input int stall, input int outwait,
                        input bit poke_start, output int lat, output bit inv_seen);
    int cyc = 0, kw = 0, oc = 0;
    lat = -1;
    inv_seen = 1'b0;
    got.delete();
    @(negedge clk);
    bus.start     = 1'b1;
    bus.decrypt   = dec;
    bus.key_size  = ks;
    bus.key_valid = (stall == 0);
    bus.out_ready = (outwait == 0);
    forever begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (!bus.busy) break;
      if (cyc > 400) begin
        lat = -2;
        break;
      end
      got.push_back(cur_event());
      if (bus.inverse) inv_seen = 1'b1;
      if (bus.out_valid && lat < 0) lat = cyc;
      kw = bus.key_req ? kw + 1 : 0;
      oc = bus.out_valid ? oc + 1 : 0;
      bus.key_valid = (kw > stall);
      bus.out_ready = (oc > outwait);
      if (poke_start && cyc == 20) begin
        bus.start    = 1'b1;
        bus.decrypt  = ~dec;
        bus.key_size = 2'b11;
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    reset = 1'b1;
    idle_inputs();
    #12;
    outs = {bus.busy, bus.ld_state, bus.sub_bytes, bus.shift_rows, bus.mix_cols, bus.add_key,
            bus.key_req, bus.out_valid, bus.err, bus.inverse, bus.key_idx, bus.round};
    total++;
    if (outs !== 18'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", outs); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_enc128();
    int lat, d;
    bit inv;
    run_op(1'b0, 2'b00, 0, 0, 1'b0, lat, inv);
    build_exp(1'b0, 10, 0, 0);
    d = first_diff();
    total++; if (lat != 53) begin bad++; $display("FAIL enc128_latency got=%0d want=53", lat); end
    total++; if (d != -1) begin bad++; $display("FAIL enc128_trace first_diff=%0d want=-1", d); end
    total++; if (count_ev(4) != 9) begin bad++; $display("FAIL enc128_mix got=%0d want=9", count_ev(4)); end
    total++; if (inv !== 1'b0) begin bad++; $display("FAIL enc128_inverse got=%0b want=0", inv); end
    total++; if (got.size() > 0 && got[0] != 1) begin bad++; $display("FAIL enc128_load got=%0d want=1", got[0]); end
  endtask

  task automatic test_dec256();
    int lat, d;
    bit inv;
    run_op(1'b1, 2'b10, 0, 0, 1'b0, lat, inv);
    build_exp(1'b1, 14, 0, 0);
    d = first_diff();
    total++; if (lat != 73) begin bad++; $display("FAIL dec256_latency got=%0d want=73", lat); end
    total++; if (d != -1) begin bad++; $display("FAIL dec256_trace first_diff=%0d want=-1", d); end
    total++; if (count_ev(4) != 13) begin bad++; $display("FAIL dec256_mix got=%0d want=13", count_ev(4)); end
    total++; if (inv !== 1'b1) begin bad++; $display("FAIL dec256_inverse got=%0b want=1", inv); end
  endtask

  task automatic test_stall192();
    int lat, d;
    bit inv;
    run_op(1'b0, 2'b01, 3, 0, 1'b0, lat, inv);
    build_exp(1'b0, 12, 3, 0);
    d = first_diff();
    total++; if (lat != 102) begin bad++; $display("FAIL stall192_latency got=%0d want=102", lat); end
    total++; if (d != -1) begin bad++; $display("FAIL stall192_trace first_diff=%0d want=-1", d); end
  endtask

  task automatic test_err();
    @(negedge clk);
    bus.start    = 1'b1;
    bus.key_size = 2'b11;
    @(negedge clk);
    bus.start = 1'b0;
    total++; if ({bus.err, bus.busy} !== 2'b10) begin bad++; $display("FAIL err_pulse got=%b want=10", {bus.err, bus.busy}); end
    @(negedge clk);
    total++; if ({bus.err, bus.busy} !== 2'b00) begin bad++; $display("FAIL err_single got=%b want=00", {bus.err, bus.busy}); end
    idle_inputs();
  endtask

  task automatic test_busy_ignore();
    int lat, d, seen = 0;
    bit inv;
    run_op(1'b0, 2'b00, 0, 0, 1'b1, lat, inv);
    build_exp(1'b0, 10, 0, 0);
    d = first_diff();
    total++; if (d != -1 || lat != 53) begin bad++; $display("FAIL busy_ignore_trace diff=%0d lat=%0d want=-1/53", d, lat); end
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.err) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL busy_ignore_idle got=%0d want=0", seen); end
  endtask

  task automatic test_out_hold();
    int lat, d;
    bit inv;
    run_op(1'b0, 2'b00, 0, 5, 1'b0, lat, inv);
    build_exp(1'b0, 10, 0, 5);
    d = first_diff();
    total++; if (count_ev(64) != 6) begin bad++; $display("FAIL out_hold_len got=%0d want=6", count_ev(64)); end
    total++; if (d != -1) begin bad++; $display("FAIL out_hold_trace first_diff=%0d want=-1", d); end
  endtask

  task automatic test_abort();
    int cyc = 0, ov = 0;
    @(negedge clk);
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (bus.round != 4'd4 && cyc < 200);
    total++; if (bus.round !== 4'd4) begin bad++; $display("FAIL abort_reach_round got=%0d want=4", bus.round); end
    bus.abort     = 1'b1;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0 || strobes() != 0) begin
      bad++; $display("FAIL abort_idle busy=%b strobes=%0d want=0/0", bus.busy, strobes());
    end
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy) ov++;
    end
    total++; if (ov != 0) begin bad++; $display("FAIL abort_quiet got=%0d want=0", ov); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, lat, d;
    bit inv;
    logic [17:0] outs;
    @(negedge clk);
    bus.start = 1'b1;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (!bus.sub_bytes && cyc < 200);
    #2 reset = 1'b1;
    #1;
    outs = {bus.busy, bus.ld_state, bus.sub_bytes, bus.shift_rows, bus.mix_cols, bus.add_key,
            bus.key_req, bus.out_valid, bus.err, bus.inverse, bus.key_idx, bus.round};
    total++; if (outs !== 18'd0) begin bad++; $display("FAIL reset_mid_async got=%h want=0", outs); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b0, 2'b00, 0, 0, 1'b0, lat, inv);
    build_exp(1'b0, 10, 0, 0);
    d = first_diff();
    total++; if (lat != 53 || d != -1) begin bad++; $display("FAIL reset_mid_restart lat=%0d diff=%0d want=53/-1", lat, d); end
  endtask

  // Back-to-back blocks with random direction, key size, key stalls and consumer backpressure
  task automatic test_back_to_back();
    int lat, d, stall, ow;
    bit dec, inv;
    logic [1:0] ks;
    for (int i = 0; i < 8; i++) begin
      dec   = 1'($urandom_range(0, 1));
      ks    = 2'($urandom_range(0, 2));
      stall = int'($urandom_range(0, 2));
      ow    = int'($urandom_range(0, 3));
      run_op(dec, ks, stall, ow, 1'b0, lat, inv);
      build_exp(dec, nr_of(ks), stall, ow);
      d = first_diff();
      total++; if (lat != exp_latency(nr_of(ks), stall)) begin
        bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, exp_latency(nr_of(ks), stall));
      end
      total++; if (d != -1 || inv != dec) begin
        bad++; $display("FAIL rand%0d_trace diff=%0d inv=%0b want=-1/%0b", i, d, inv, dec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enc128();
    test_dec256();
    test_stall192();
    test_err();
    test_busy_ignore();
    test_out_hold();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have no parameters; the round count is derived at run time from key_size.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 reset  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  request to begin one block operation; sampled only in IDLE.
REQ-005 decrypt  in  1  0 = encrypt, 1 = decrypt; captured when start is accepted.
REQ-006 key_size  in  2  00 = 128-bit key (Nr=10), 01 = 192-bit (Nr=12), 10 = 256-bit (Nr=14), 11 = illegal; captured with start.
REQ-007 abort  in  1  synchronous cancel of the operation in flight.
REQ-008 key_valid  in  1  key expander has round key key_idx ready.
REQ-009 out_ready  in  1  consumer accepts the result.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 ld_state  out  1  one-cycle strobe: datapath loads the input block.
REQ-012 sub_bytes, shift_rows, mix_cols, add_key  out  1 each  one-cycle datapath op strobes.
REQ-013 inverse  out  1  registered copy of the captured decrypt bit; selects the inverse ops.
REQ-014 key_req  out  1  request for round key key_idx.
REQ-015 key_idx  out  4  index (0..14) of the requested or applied round key.
REQ-016 round  out  4  current round number.
REQ-017 out_valid  out  1  result block is valid.
REQ-018 err  out  1  one-cycle pulse when start is rejected.

Function
REQ-019 States SHALL be IDLE, LOAD, KWAIT, ADDK, SUB, SHIFT, MIX and OUT; exactly one datapath strobe SHALL be high per op state, and none in IDLE, KWAIT or OUT.
REQ-020 In IDLE with start=1 and key_size!=11: capture decrypt and Nr, then enter LOAD next cycle.
REQ-021 In IDLE with start=1 and key_size==11: pulse err for one cycle and stay in IDLE.
REQ-022 LOAD: assert ld_state; next state is KWAIT.
REQ-023 KWAIT: assert key_req with a stable key_idx; stay while key_valid=0; go to ADDK when key_valid=1.
REQ-024 ADDK: assert add_key; key_idx is held from KWAIT.
REQ-025 Encrypt sequence:
- round 0: KWAIT/ADDK with key_idx 0;
- rounds 1..Nr-1: SUB, SHIFT, MIX, KWAIT, ADDK with key_idx = round;
- round Nr: SUB, SHIFT, KWAIT, ADDK with key_idx Nr, then OUT.
REQ-026 Decrypt sequence, with SUB/SHIFT/MIX driving inverse ops via inverse=1:
- round 0: KWAIT/ADDK with key_idx Nr;
- rounds 1..Nr-1: SHIFT, SUB, KWAIT, ADDK with key_idx Nr-round, then MIX;
- round Nr: SHIFT, SUB, KWAIT, ADDK with key_idx 0, then OUT.
REQ-027 round SHALL increment by 1 on leaving each ADDK, except in the final round; it never wraps past Nr.
REQ-028 Latency with key_valid held high, counting the start-sampling edge as cycle 0:
- ld_state high in cycle 1;
- out_valid first high in cycle 8+5*(Nr-1), i.e. 53, 63 and 73 for the three key sizes.
REQ-029 Each cycle of key_valid=0 in KWAIT SHALL add exactly one cycle of latency.
REQ-030 OUT: hold out_valid high until out_ready=1, then return to IDLE on the next cycle. If out_ready is already high on entry, out_valid lasts one cycle.
REQ-031 abort=1 in any non-IDLE state: go to IDLE on the next edge; no out_valid and no further strobes. abort outranks key_valid and out_ready in the same cycle.
REQ-032 start, decrypt and key_size SHALL be ignored while busy=1.
REQ-033 The earliest new start is the cycle in which the controller is back in IDLE; back-to-back blocks are therefore separated by at least one IDLE cycle.
REQ-034 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs except key_req/key_idx, which are derived from state.

Reset
REQ-035 While reset=1, regardless of clk:
- state IDLE;
- busy, ld_state, all op strobes, key_req, out_valid, err, inverse = 0;
- key_idx = 0, round = 0.
REQ-036 Reset asserted mid-operation SHALL abandon the block with no out_valid; the first start after deassertion is accepted normally.

Verification
REQ-037 Encrypt, key_size=00, key_valid=1, out_ready=1 -> ld_state at cycle 1; add_key key_idx sequence 0..10; 9 mix_cols pulses; out_valid at cycle 53 for one cycle.
REQ-038 Decrypt, key_size=10 -> inverse=1; add_key key_idx sequence 14,13..0; 13 mix_cols pulses, each after add_key; out_valid at cycle 73.
REQ-039 key_size=01 with key_valid low for 3 cycles in each KWAIT (13 KWAITs) -> out_valid at cycle 63+39=102.
REQ-040 start with key_size=11 -> err pulses once, busy stays 0; start asserted while busy -> ignored, no second operation.
REQ-041 out_ready held low for 5 cycles in OUT -> out_valid high for 6 cycles, then IDLE.
REQ-042 abort at round 4, and separately async reset mid-SUB -> IDLE next edge (reset immediately), no out_valid; the next encrypt completes at cycle 53.
